// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared definitions for the GPIO pad controller slice.
//   - Pin mode encodings used by the output decode.
//   - PWM channel count, which sets the width of the PWM bus.
//   - A small struct that carries the pad drive pair (value + enable).
package gpio_pkg;

   localparam logic [3:0] GPIO_MODE_IN       = 4'h0;
   localparam logic [3:0] GPIO_MODE_TOTEM    = 4'h1;
   localparam logic [3:0] GPIO_MODE_OD       = 4'h2;
   localparam logic [3:0] GPIO_MODE_WOR      = 4'h3;
   localparam logic [3:0] GPIO_MODE_PWM_BASE = 4'h8;

   localparam int PWM_CHANNELS = 8;

   // Pad drive pair produced by the mode decode and held in the output registers
   typedef struct packed {
      logic out;
      logic oe;
   } pad_drive_t;

endpackage : gpio_pkg

// File: rtl/gpio_in_filt.sv
// gpio_in_filt
// Input side of a GPIO pin: synchronizer, glitch filter, edge detect and
// sticky event flags.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   pad_in      - raw asynchronous pad level
//   filt_len    - number of extra clocks a new level must persist (0 = none)
//   evt_clr     - single-cycle pulse clearing both sticky flags
//   pin_din     - filtered input level
//   evt_rise    - sticky flag, filtered rising edge seen
//   evt_fall    - sticky flag, filtered falling edge seen
//   evt_pulse   - one-clock strobe following any filtered edge
module gpio_in_filt #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_BITS   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pad_in,
   input  logic [FILT_BITS-1:0] filt_len,
   input  logic                 evt_clr,
   output logic                 pin_din,
   output logic                 evt_rise,
   output logic                 evt_fall,
   output logic                 evt_pulse
);

   localparam logic [FILT_BITS-1:0] CNT_ONE = {{(FILT_BITS-1){1'b0}}, 1'b1};

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [FILT_BITS-1:0]   cnt;
   logic                   din_d;
   logic                   rise;
   logic                   fall;

   // Shift the raw pad level through the synchronizer chain; the last
   // stage is the first point where the level is safe to use.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // Glitch filter: count consecutive clocks where the synchronized level
   // disagrees with the committed level. Any agreement restarts the count,
   // so short pulses never commit. The >= compare means that lowering
   // filt_len below the running count commits on the very next mismatch,
   // and because the count is bounded by filt_len it can never wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         pin_din <= 1'b0;
      end else if (sync == pin_din) begin
         cnt <= '0;
      end else if (cnt >= filt_len) begin
         pin_din <= sync;
         cnt     <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   assign rise = pin_din & ~din_d;
   assign fall = ~pin_din & din_d;

   // Edge detection and sticky flags. A set in the same clock as a clear
   // wins so that software never loses an event it has not yet seen.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         din_d     <= 1'b0;
         evt_pulse <= 1'b0;
         evt_rise  <= 1'b0;
         evt_fall  <= 1'b0;
      end else begin
         din_d     <= pin_din;
         evt_pulse <= rise | fall;
         evt_rise  <= rise | (evt_rise & ~evt_clr);
         evt_fall  <= fall | (evt_fall & ~evt_clr);
      end
   end

endmodule : gpio_in_filt

// File: rtl/gpio_pin_ctrl.sv
// gpio_pin_ctrl
// Per-pin GPIO pad controller sitting after the PWM generators.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   pin_mode    - 0 input, 1 totem-pole, 2 open-drain, 3 wired-or,
//                 4-7 reserved (hi-Z), 8-15 drive from PWM0-PWM7
//   pin_dout    - software output data
//   pwm_bus     - registered PWM outputs, bit n = PWMn
//   filt_len    - input glitch-filter length in clocks
//   evt_clr     - clears both sticky event flags
//   pad_in      - raw pad input
//   pad_out     - pad output value
//   pad_oe      - pad output enable (1 = drive)
//   pin_din     - filtered input level
//   evt_rise    - sticky rising-edge flag
//   evt_fall    - sticky falling-edge flag
//   evt_pulse   - one-clock strobe on any filtered edge
module gpio_pin_ctrl
   import gpio_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_BITS   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              pin_mode,
   input  logic                    pin_dout,
   input  logic [PWM_CHANNELS-1:0] pwm_bus,
   input  logic [FILT_BITS-1:0]    filt_len,
   input  logic                    evt_clr,
   input  logic                    pad_in,
   output logic                    pad_out,
   output logic                    pad_oe,
   output logic                    pin_din,
   output logic                    evt_rise,
   output logic                    evt_fall,
   output logic                    evt_pulse
);

   logic [3:0] mode_p1;
   logic       dout_p1;
   pad_drive_t drive_next;

   // Register the software-controlled mode and data once. PWM bits are
   // already registered upstream, so they skip this stage and reach the
   // pad one clock sooner than the software fields.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_p1 <= GPIO_MODE_IN;
         dout_p1 <= 1'b0;
      end else begin
         mode_p1 <= pin_mode;
         dout_p1 <= pin_dout;
      end
   end

   // Mode decode. Open-drain only ever drives low and releases for a 1;
   // wired-or only ever drives high and releases for a 0. Reserved modes
   // behave like input mode so a bad register write leaves the pad hi-Z.
   always_comb begin
      drive_next = '0;
      if (mode_p1[3]) begin
         drive_next.oe  = 1'b1;
         drive_next.out = pwm_bus[mode_p1[2:0]];
      end else begin
         case (mode_p1)
            GPIO_MODE_TOTEM: begin
               drive_next.oe  = 1'b1;
               drive_next.out = dout_p1;
            end
            GPIO_MODE_OD: begin
               drive_next.oe  = ~dout_p1;
               drive_next.out = 1'b0;
            end
            GPIO_MODE_WOR: begin
               drive_next.oe  = dout_p1;
               drive_next.out = 1'b1;
            end
            default: begin
               drive_next = '0;
            end
         endcase
      end
   end

   // Output registers: a mode change simply takes effect here, with no
   // attempt to finish a PWM period in progress. Reset tri-states at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pad_out <= 1'b0;
         pad_oe  <= 1'b0;
      end else begin
         pad_out <= drive_next.out;
         pad_oe  <= drive_next.oe;
      end
   end

   // The input path is always live, so driven modes read back the pad.
   gpio_in_filt #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_BITS  (FILT_BITS)
   ) u_in_filt (
      .clk      (clk),
      .reset    (reset),
      .pad_in   (pad_in),
      .filt_len (filt_len),
      .evt_clr  (evt_clr),
      .pin_din  (pin_din),
      .evt_rise (evt_rise),
      .evt_fall (evt_fall),
      .evt_pulse(evt_pulse)
   );

endmodule : gpio_pin_ctrl

// File: tb/tb_gpio_pin_ctrl.sv
// tb_gpio_pin_ctrl
// Directed testbench for gpio_pin_ctrl (SYNC_STAGES=2, FILT_BITS=4).
// Inputs change 1 ns after a rising clock edge and outputs are sampled
// at that same point, away from the active edge.
module tb_gpio_pin_ctrl;
   import gpio_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] pin_mode;
   logic       pin_dout;
   logic [7:0] pwm_bus;
   logic [3:0] filt_len;
   logic       evt_clr;
   logic       pad_in;
   logic       pad_out;
   logic       pad_oe;
   logic       pin_din;
   logic       evt_rise;
   logic       evt_fall;
   logic       evt_pulse;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gpio_pin_ctrl #(
      .SYNC_STAGES(2),
      .FILT_BITS  (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .pin_mode (pin_mode),
      .pin_dout (pin_dout),
      .pwm_bus  (pwm_bus),
      .filt_len (filt_len),
      .evt_clr  (evt_clr),
      .pad_in   (pad_in),
      .pad_out  (pad_out),
      .pad_oe   (pad_oe),
      .pin_din  (pin_din),
      .evt_rise (evt_rise),
      .evt_fall (evt_fall),
      .evt_pulse(evt_pulse)
   );

   // Advance n rising edges and settle 1 ns past the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reset state with the pad high, then the first filtered rise
   task automatic test_reset();
      pad_in = 1'b1;
      filt_len = 4'd3;
      step(2);
      checks++; if (pad_oe !== 1'b0) begin errors++; $display("[TB] FAIL rst_oe got %b want 0", pad_oe); end
      checks++; if (pad_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_out got %b want 0", pad_out); end
      checks++; if (pin_din !== 1'b0) begin errors++; $display("[TB] FAIL rst_din got %b want 0", pin_din); end
      checks++; if ({evt_rise, evt_fall, evt_pulse} !== 3'b000) begin errors++; $display("[TB] FAIL rst_flags got %b want 000", {evt_rise, evt_fall, evt_pulse}); end
      reset = 1'b0;
      step(5);
      checks++; if (pin_din !== 1'b0) begin errors++; $display("[TB] FAIL rel_din_clk5 got %b want 0", pin_din); end
      step(1);
      checks++; if (pin_din !== 1'b1) begin errors++; $display("[TB] FAIL rel_din_clk6 got %b want 1", pin_din); end
      checks++; if (evt_pulse !== 1'b0) begin errors++; $display("[TB] FAIL rel_pulse_clk6 got %b want 0", evt_pulse); end
      step(1);
      checks++; if (evt_pulse !== 1'b1) begin errors++; $display("[TB] FAIL rel_pulse_clk7 got %b want 1", evt_pulse); end
      checks++; if (evt_rise !== 1'b1) begin errors++; $display("[TB] FAIL rel_rise_clk7 got %b want 1", evt_rise); end
      step(1);
      checks++; if (evt_pulse !== 1'b0) begin errors++; $display("[TB] FAIL rel_pulse_clk8 got %b want 0", evt_pulse); end
      checks++; if (evt_rise !== 1'b1) begin errors++; $display("[TB] FAIL rel_rise_clk8 got %b want 1", evt_rise); end
   endtask

   // A 3-clock pulse is rejected; a 4-clock pulse commits both edges
   task automatic test_glitch_filter();
      pad_in = 1'b0;
      step(10);
      evt_clr = 1'b1;
      step(1);
      evt_clr = 1'b0;
      checks++; if ({pin_din, evt_rise, evt_fall} !== 3'b000) begin errors++; $display("[TB] FAIL gl_idle got %b want 000", {pin_din, evt_rise, evt_fall}); end
      pad_in = 1'b1;
      step(3);
      pad_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         checks++; if ({pin_din, evt_pulse} !== 2'b00) begin errors++; $display("[TB] FAIL gl_short_%0d got %b want 00", i, {pin_din, evt_pulse}); end
      end
      checks++; if (evt_rise !== 1'b0) begin errors++; $display("[TB] FAIL gl_short_rise got %b want 0", evt_rise); end
      pad_in = 1'b1;
      step(4);
      pad_in = 1'b0;
      step(1);
      checks++; if (pin_din !== 1'b0) begin errors++; $display("[TB] FAIL gl_long_clk5 got %b want 0", pin_din); end
      step(1);
      checks++; if (pin_din !== 1'b1) begin errors++; $display("[TB] FAIL gl_long_clk6 got %b want 1", pin_din); end
      step(3);
      checks++; if (pin_din !== 1'b1) begin errors++; $display("[TB] FAIL gl_long_clk9 got %b want 1", pin_din); end
      step(1);
      checks++; if (pin_din !== 1'b0) begin errors++; $display("[TB] FAIL gl_long_clk10 got %b want 0", pin_din); end
      step(2);
      checks++; if ({evt_rise, evt_fall} !== 2'b11) begin errors++; $display("[TB] FAIL gl_long_flags got %b want 11", {evt_rise, evt_fall}); end
   endtask

   // Open-drain, wired-or and totem-pole decode with 2-clock latency
   task automatic test_output_modes();
      pin_mode = GPIO_MODE_OD;
      pin_dout = 1'b0;
      step(1);
      checks++; if (pad_oe !== 1'b0) begin errors++; $display("[TB] FAIL od_latency got oe=%b want 0", pad_oe); end
      step(1);
      checks++; if ({pad_out, pad_oe} !== 2'b01) begin errors++; $display("[TB] FAIL od_d0 got out/oe=%b want 01", {pad_out, pad_oe}); end
      pin_dout = 1'b1;
      step(2);
      checks++; if ({pad_out, pad_oe} !== 2'b00) begin errors++; $display("[TB] FAIL od_d1 got out/oe=%b want 00", {pad_out, pad_oe}); end
      pin_dout = 1'b0;
      step(2);
      checks++; if ({pad_out, pad_oe} !== 2'b01) begin errors++; $display("[TB] FAIL od_d0b got out/oe=%b want 01", {pad_out, pad_oe}); end
      pin_mode = GPIO_MODE_WOR;
      pin_dout = 1'b1;
      step(2);
      checks++; if ({pad_out, pad_oe} !== 2'b11) begin errors++; $display("[TB] FAIL wor_d1 got out/oe=%b want 11", {pad_out, pad_oe}); end
      pin_dout = 1'b0;
      step(2);
      checks++; if ({pad_out, pad_oe} !== 2'b10) begin errors++; $display("[TB] FAIL wor_d0 got out/oe=%b want 10", {pad_out, pad_oe}); end
      pin_mode = GPIO_MODE_TOTEM;
      pin_dout = 1'b1;
      step(2);
      checks++; if ({pad_out, pad_oe} !== 2'b11) begin errors++; $display("[TB] FAIL totem_d1 got out/oe=%b want 11", {pad_out, pad_oe}); end
      pin_dout = 1'b0;
      step(2);
      checks++; if ({pad_out, pad_oe} !== 2'b01) begin errors++; $display("[TB] FAIL totem_d0 got out/oe=%b want 01", {pad_out, pad_oe}); end
   endtask

   // PWM3 routed to the pad with 1-clock delay, then a reserved mode
   task automatic test_pwm();
      logic prev_bit;
      logic cur_bit;
      pin_mode = 4'hB;
      pwm_bus = 8'h00;
      step(2);
      checks++; if ({pad_out, pad_oe} !== 2'b01) begin errors++; $display("[TB] FAIL pwm_enter got out/oe=%b want 01", {pad_out, pad_oe}); end
      prev_bit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cur_bit = ((i / 5) % 2) == 1;
         pwm_bus = {4'b0000, cur_bit, 3'b000};
         #1;
         checks++; if (pad_out !== prev_bit) begin errors++; $display("[TB] FAIL pwm_hold_%0d got %b want %b", i, pad_out, prev_bit); end
         step(1);
         checks++; if (pad_out !== cur_bit) begin errors++; $display("[TB] FAIL pwm_follow_%0d got %b want %b", i, pad_out, cur_bit); end
         prev_bit = cur_bit;
      end
      pwm_bus = 8'hF7;
      step(1);
      checks++; if (pad_out !== 1'b0) begin errors++; $display("[TB] FAIL pwm_select_lo got %b want 0", pad_out); end
      pwm_bus = 8'h08;
      step(1);
      checks++; if (pad_out !== 1'b1) begin errors++; $display("[TB] FAIL pwm_select_hi got %b want 1", pad_out); end
      pin_mode = 4'h5;
      step(1);
      checks++; if (pad_oe !== 1'b1) begin errors++; $display("[TB] FAIL rsv_latency got oe=%b want 1", pad_oe); end
      step(1);
      checks++; if ({pad_out, pad_oe} !== 2'b00) begin errors++; $display("[TB] FAIL rsv_mode got out/oe=%b want 00", {pad_out, pad_oe}); end
      pwm_bus = 8'h00;
   endtask

   // Set and clear in the same cycle: set wins; then a lone clear
   task automatic test_set_clr_race();
      filt_len = 4'd0;
      evt_clr = 1'b1;
      step(1);
      evt_clr = 1'b0;
      checks++; if ({evt_rise, evt_fall} !== 2'b00) begin errors++; $display("[TB] FAIL race_pre got %b want 00", {evt_rise, evt_fall}); end
      pad_in = 1'b1;
      step(3);
      checks++; if ({pin_din, evt_rise} !== 2'b10) begin errors++; $display("[TB] FAIL race_commit got din/rise=%b want 10", {pin_din, evt_rise}); end
      evt_clr = 1'b1;
      step(1);
      checks++; if (evt_rise !== 1'b1) begin errors++; $display("[TB] FAIL race_set_wins got %b want 1", evt_rise); end
      checks++; if (evt_pulse !== 1'b1) begin errors++; $display("[TB] FAIL race_pulse got %b want 1", evt_pulse); end
      step(1);
      evt_clr = 1'b0;
      checks++; if ({evt_rise, evt_fall} !== 2'b00) begin errors++; $display("[TB] FAIL race_clear got %b want 00", {evt_rise, evt_fall}); end
   endtask

   // Shrinking filt_len below the running count commits on the next clock
   task automatic test_filt_shrink();
      pad_in = 1'b0;
      filt_len = 4'd0;
      step(5);
      evt_clr = 1'b1;
      step(1);
      evt_clr = 1'b0;
      filt_len = 4'd15;
      step(3);
      checks++; if (pin_din !== 1'b0) begin errors++; $display("[TB] FAIL shrink_idle got %b want 0", pin_din); end
      pad_in = 1'b1;
      step(12);
      checks++; if (pin_din !== 1'b0) begin errors++; $display("[TB] FAIL shrink_cnt10 got %b want 0", pin_din); end
      filt_len = 4'd2;
      step(1);
      checks++; if (pin_din !== 1'b1) begin errors++; $display("[TB] FAIL shrink_commit got %b want 1", pin_din); end
      pad_in = 1'b0;
      step(4);
      checks++; if (pin_din !== 1'b1) begin errors++; $display("[TB] FAIL shrink_fall_clk4 got %b want 1", pin_din); end
      step(1);
      checks++; if (pin_din !== 1'b0) begin errors++; $display("[TB] FAIL shrink_fall_clk5 got %b want 0", pin_din); end
   endtask

   // Maximum filt_len: 2 sync clocks plus 16 filter clocks, no wrap
   task automatic test_filt_max();
      filt_len = 4'd15;
      step(4);
      pad_in = 1'b1;
      step(17);
      checks++; if (pin_din !== 1'b0) begin errors++; $display("[TB] FAIL max_clk17 got %b want 0", pin_din); end
      step(1);
      checks++; if (pin_din !== 1'b1) begin errors++; $display("[TB] FAIL max_clk18 got %b want 1", pin_din); end
   endtask

   // Reset mid-operation tri-states the pad without waiting for a clock
   task automatic test_reset_mid();
      pin_mode = GPIO_MODE_TOTEM;
      pin_dout = 1'b1;
      step(3);
      checks++; if ({pad_out, pad_oe} !== 2'b11) begin errors++; $display("[TB] FAIL mid_drive got out/oe=%b want 11", {pad_out, pad_oe}); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if ({pad_out, pad_oe} !== 2'b00) begin errors++; $display("[TB] FAIL mid_tristate got out/oe=%b want 00", {pad_out, pad_oe}); end
      checks++; if (pin_din !== 1'b0) begin errors++; $display("[TB] FAIL mid_din got %b want 0", pin_din); end
      step(1);
      reset = 1'b0;
      step(1);
      checks++; if (pad_oe !== 1'b0) begin errors++; $display("[TB] FAIL mid_rel_latency got oe=%b want 0", pad_oe); end
      step(1);
      checks++; if ({pad_out, pad_oe} !== 2'b11) begin errors++; $display("[TB] FAIL mid_rel_drive got out/oe=%b want 11", {pad_out, pad_oe}); end
   endtask

   // Hard bound on simulation time in case anything stalls
   initial begin
      #200000;
      $display("[TB] FAIL timeout got running want finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset = 1'b1;
      pin_mode = GPIO_MODE_IN;
      pin_dout = 1'b0;
      pwm_bus = 8'h00;
      filt_len = 4'd0;
      evt_clr = 1'b0;
      pad_in = 1'b0;
      test_reset();
      test_glitch_filter();
      test_output_modes();
      test_pwm();
      test_set_clr_race();
      test_filt_shrink();
      test_filt_max();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_gpio_pin_ctrl
